timer_apb_master: RTL and testbench

//   Upstream APB requester for timer_top. Converts a simple valid/ready register-request

---
 rtl/timer_pkg.sv | 31 +++
 rtl/timer_apb_master_if.sv | 47 ++++
 rtl/timer_apb_master.sv | 139 +++++++++++++
 tb/tb_timer_apb_master.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer APB requester: FSM encoding, bus widths and
// the timer register map.
package timer_pkg;

  localparam int unsigned APB_ADDR_W = 12;
  localparam int unsigned APB_DATA_W = 32;
  localparam int unsigned APB_STRB_W = APB_DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  localparam logic [APB_ADDR_W-1:0] TIM_TCR  = 12'h000;
  localparam logic [APB_ADDR_W-1:0] TIM_TLR  = 12'h004;
  localparam logic [APB_ADDR_W-1:0] TIM_TCNT = 12'h008;
  localparam logic [APB_ADDR_W-1:0] TIM_TCMP = 12'h00C;
  localparam logic [APB_ADDR_W-1:0] TIM_TSR  = 12'h010;
  localparam logic [APB_ADDR_W-1:0] TIM_TIER = 12'h014;
  localparam logic [APB_ADDR_W-1:0] TIM_TPRE = 12'h018;
  localparam logic [APB_ADDR_W-1:0] TIM_TCAP = 12'h01C;

  localparam logic [APB_DATA_W-1:0] TCR_RST_VAL = 32'h0000_0000;

  // Word-aligned check on the two low address bits.
  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/timer_apb_master_if.sv
// Request/response port plus APB4 bus of the timer requester; master is the
// requester's own view, slave is the view of whoever sits around it.
interface timer_apb_master_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_strb;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic              tim_psel;
  logic              tim_penable;
  logic              tim_pwrite;
  logic [ADDR_W-1:0] tim_paddr;
  logic [DATA_W-1:0] tim_pwdata;
  logic [STRB_W-1:0] tim_pstrb;
  logic [DATA_W-1:0] tim_prdata;
  logic              tim_pready;
  logic              tim_pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
    input  tim_prdata, tim_pready, tim_pslverr
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
    output tim_prdata, tim_pready, tim_pslverr
  );

endinterface

// File: rtl/timer_apb_master.sv
// Single-outstanding APB4 requester for timer_top: valid/ready request in,
// one-cycle response pulse out, with a bus-hang timeout on the ACCESS phase.
module timer_apb_master
  import timer_pkg::*;
#(
  parameter int unsigned ADDR_W  = APB_ADDR_W,
  parameter int unsigned DATA_W  = APB_DATA_W,
  parameter int unsigned TIMEOUT = 16
) (
  input logic                sys_clk,
  input logic                sys_rst_n,
  timer_apb_master_if.master bus
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W:0] TO_LIM = 9'(TIMEOUT);
  localparam bit             TO_EN  = (TIMEOUT != 0);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
  } apb_cmd_t;

  state_e            state_q, state_d;
  apb_cmd_t          cmd_q, cmd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W:0]    cnt_inc;
  logic              req_ready_q, req_ready_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              accept;

  assign accept  = bus.req_valid && req_ready_q;
  assign cnt_inc = {1'b0, cnt_q} + 9'd1;

  // Next-state, command capture, timeout counting and response formation.
  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    cnt_d         = cnt_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_word_aligned(bus.req_addr[1:0])) begin
            cmd_d.write = bus.req_write;
            cmd_d.addr  = bus.req_addr;
            cmd_d.wdata = bus.req_wdata;
            cmd_d.strb  = bus.req_write ? bus.req_strb : '0;
            cnt_d       = '0;
            state_d     = ST_SETUP;
          end else begin
            // Misaligned: answer with an error without touching the bus.
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b0;
          end
        end
      end

      ST_SETUP: state_d = ST_ACCESS;

      ST_ACCESS: begin
        if (bus.tim_pready) begin
          state_d       = ST_IDLE;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = bus.tim_pslverr;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = (!cmd_q.write && !bus.tim_pslverr) ? bus.tim_prdata : '0;
        end else if (TO_EN && (cnt_inc == TO_LIM)) begin
          state_d       = ST_IDLE;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end

      default: state_d = ST_IDLE;
    endcase

    req_ready_d = (state_d == ST_IDLE);
    psel_d      = (state_d != ST_IDLE);
    penable_d   = (state_d == ST_ACCESS);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q       <= ST_IDLE;
      cmd_q         <= '0;
      cnt_q         <= '0;
      req_ready_q   <= 1'b1;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      cnt_q         <= cnt_d;
      req_ready_q   <= req_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.tim_psel    = psel_q;
  assign bus.tim_penable = penable_q;
  assign bus.tim_pwrite  = cmd_q.write;
  assign bus.tim_paddr   = cmd_q.addr;
  assign bus.tim_pwdata  = cmd_q.wdata;
  assign bus.tim_pstrb   = cmd_q.strb;

endmodule

// File: tb/tb_timer_apb_master.sv
// Bench for timer_apb_master: behavioural APB register slave, directed and
// random transfers scored against an expected-memory/expected-timing model.
module tb_timer_apb_master;
  import timer_pkg::*;

  localparam int unsigned TO = 16;

  logic sys_clk;
  logic sys_rst_n;

  timer_apb_master_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  timer_apb_master #(.ADDR_W(12), .DATA_W(32), .TIMEOUT(TO)) u_dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Slave side: register file, programmable wait states, error and hang knobs.
  logic [31:0] slv_mem [8];
  logic [31:0] ref_mem [8];
  int          sl_ws;
  bit          sl_err;
  bit          sl_hang;
  int          acc_cnt;

  assign bus.tim_pready  = bus.tim_psel && bus.tim_penable && !sl_hang && (acc_cnt >= sl_ws);
  assign bus.tim_pslverr = bus.tim_pready ? sl_err : 1'b1;
  assign bus.tim_prdata  = slv_mem[bus.tim_paddr[4:2]];

  always @(posedge sys_clk) begin
    if (bus.tim_psel && bus.tim_penable && !bus.tim_pready) acc_cnt <= acc_cnt + 1;
    else                                                   acc_cnt <= 0;
    if (bus.tim_psel && bus.tim_penable && bus.tim_pready && bus.tim_pwrite && !sl_err)
      for (int b = 0; b < 4; b++)
        if (bus.tim_pstrb[b]) slv_mem[bus.tim_paddr[4:2]][8*b +: 8] <= bus.tim_pwdata[8*b +: 8];
  end

  // Protocol monitor: bus stable while selected, no ACCESS without SETUP, no read strobes.
  logic        prev_psel;
  logic [11:0] prev_addr;
  logic [31:0] prev_wdata;
  logic [3:0]  prev_strb;
  logic        prev_write;

  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      prev_psel = 1'b0;
    end else begin
      if (bus.tim_psel && prev_psel)
        chk("mon_stable", {bus.tim_pwrite, bus.tim_pstrb, bus.tim_paddr, bus.tim_pwdata},
                          {prev_write, prev_strb, prev_addr, prev_wdata});
      if (bus.tim_penable) chk("mon_setup_first", 64'(prev_psel), 64'd1);
      if (bus.tim_psel && !bus.tim_pwrite) chk("mon_rd_strb", 64'(bus.tim_pstrb), 64'd0);
      prev_psel  = bus.tim_psel;
      prev_addr  = bus.tim_paddr;
      prev_wdata = bus.tim_pwdata;
      prev_strb  = bus.tim_pstrb;
      prev_write = bus.tim_pwrite;
    end
  end

  task automatic txn(input bit wr, input logic [11:0] addr, input logic [31:0] wd,
                     input logic [3:0] st, input int ws, input bit serr, input bit hang,
                     input string tag);
    bit          aligned, exp_err, exp_to, got, saw_psel;
    int          exp_cyc, cyc, idx;
    logic [31:0] exp_rd;
    logic [3:0]  exp_strb;

    aligned  = (addr % 4) == 0;
    idx      = int'(addr[4:2]);
    exp_err  = !aligned || hang || serr;
    exp_to   = aligned && hang;
    exp_cyc  = !aligned ? 1 : (hang ? 2 + int'(TO) : 3 + ws);
    exp_rd   = (!wr && !exp_err) ? ref_mem[idx] : 32'd0;
    exp_strb = wr ? st : 4'd0;

    @(negedge sys_clk);
    sl_ws = ws; sl_err = serr; sl_hang = hang;
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr;
    bus.req_wdata = wd;   bus.req_strb  = st;
    chk($sformatf("%s_req_ready", tag), 64'(bus.req_ready), 64'd1);
    @(posedge sys_clk); #1;
    bus.req_valid = 1'b0;

    cyc = 1; got = 0; saw_psel = 0;
    while (cyc <= 100) begin
      if (bus.tim_psel) saw_psel = 1;
      if (aligned && cyc == 1)
        chk($sformatf("%s_setup", tag),
            {bus.tim_psel, bus.tim_penable, bus.tim_pwrite, bus.tim_pstrb, bus.tim_paddr, bus.tim_pwdata},
            {1'b1, 1'b0, wr, exp_strb, addr, wr ? wd : bus.tim_pwdata});
      if (aligned && cyc == 2)
        chk($sformatf("%s_access", tag), 64'({bus.tim_psel, bus.tim_penable}), 64'b11);
      if (bus.rsp_valid) begin
        got = 1;
        break;
      end
      @(posedge sys_clk); #1;
      cyc++;
    end

    chk($sformatf("%s_rsp_seen", tag), 64'(got), 64'd1);
    chk($sformatf("%s_latency", tag), 64'(cyc), 64'(exp_cyc));
    chk($sformatf("%s_err_to", tag), 64'({bus.rsp_err, bus.rsp_timeout}), 64'({exp_err, exp_to}));
    chk($sformatf("%s_rdata", tag), 64'(bus.rsp_rdata), 64'(exp_rd));
    chk($sformatf("%s_bus_idle", tag), 64'({bus.tim_psel, bus.tim_penable, bus.req_ready}), 64'b001);
    chk($sformatf("%s_psel_used", tag), 64'(saw_psel), 64'(aligned));

    if (wr && aligned && !hang && !serr)
      for (int b = 0; b < 4; b++)
        if (st[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];

    @(posedge sys_clk); #1;
    chk($sformatf("%s_pulse", tag), 64'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}),
        64'({1'b0, exp_err, exp_rd}));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      slv_mem[i] = (i == 0) ? TCR_RST_VAL : 32'h1000_0000 * 32'(i) + 32'h0000_0A5A;
      ref_mem[i] = slv_mem[i];
    end
    sl_ws = 0; sl_err = 0; sl_hang = 0; acc_cnt = 0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_strb  = '0;
    sys_rst_n = 1'b0;

    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset_outputs",
        64'({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.tim_psel,
             bus.tim_penable, bus.tim_pwrite, bus.tim_pstrb}), 64'b1_0000_0_0_0000);
    chk("reset_rdata_addr", {bus.rsp_rdata, 20'd0, bus.tim_paddr}, 64'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    txn(1'b0, TIM_TCR, 32'd0, 4'hF, 0, 1'b0, 1'b0, "rd_tcr_rst");
    txn(1'b1, TIM_TLR, 32'h0000_00FF, 4'hF, 0, 1'b0, 1'b0, "wr_tlr");
    txn(1'b0, TIM_TLR, 32'd0, 4'hF, 0, 1'b0, 1'b0, "rd_tlr");
    txn(1'b0, TIM_TCNT, 32'd0, 4'h0, 3, 1'b1, 1'b0, "slverr_ws3");
    txn(1'b0, TIM_TCMP, 32'd0, 4'h0, 0, 1'b0, 1'b1, "timeout_rd");
    txn(1'b1, TIM_TSR, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 1'b1, "timeout_wr");
    txn(1'b0, TIM_TSR, 32'd0, 4'h0, 15, 1'b0, 1'b0, "ready_on_terminal");
    txn(1'b0, 12'h006, 32'd0, 4'h0, 0, 1'b0, 1'b0, "misaligned");
    txn(1'b1, TIM_TIER, 32'h1234_5678, 4'b0101, 2, 1'b0, 1'b0, "wr_partial");
    txn(1'b0, TIM_TIER, 32'd0, 4'h0, 1, 1'b0, 1'b0, "rd_partial");

    for (int n = 0; n < 30; n++) begin
      bit          wr, mis, serr, hang;
      logic [11:0] a;
      wr   = 1'($urandom_range(0, 1));
      mis  = ($urandom_range(0, 6) == 0);
      serr = ($urandom_range(0, 7) == 0);
      hang = ($urandom_range(0, 14) == 0);
      a    = 12'($urandom_range(0, 7) * 4 + (mis ? $urandom_range(1, 3) : 0));
      txn(wr, a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 4)),
          serr, hang, $sformatf("rnd%0d", n));
    end

    // Reset while the bus is in ACCESS: transfer dies silently.
    @(negedge sys_clk);
    sl_hang = 1'b1;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = TIM_TLR;
    @(posedge sys_clk); #1;
    bus.req_valid = 1'b0;
    @(posedge sys_clk); #1;
    chk("rst_mid_in_access", 64'({bus.tim_psel, bus.tim_penable}), 64'b11);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    @(posedge sys_clk); #1;
    chk("rst_mid_dropped", 64'({bus.tim_psel, bus.tim_penable, bus.rsp_valid}), 64'b000);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    sl_hang   = 1'b0;
    repeat (3) begin
      @(posedge sys_clk); #1;
      chk("rst_mid_no_rsp", 64'({bus.rsp_valid, bus.tim_psel}), 64'b00);
    end
    txn(1'b0, TIM_TLR, 32'd0, 4'h0, 0, 1'b0, 1'b0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
